// File: rtl/dec2bin_pkg.sv
// dec2bin_pkg
// Shared definitions for the BCD-digit to binary accumulator:
//   state_e   - controller states (ACCUM collects digits, OUT presents result)
//   DIGIT_W   - width of one BCD digit
//   MAX_DIGIT - largest legal decimal digit
package dec2bin_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      OUT   = 1'b1
   } state_e;

   localparam int                  DIGIT_W   = 4;
   localparam logic [DIGIT_W-1:0]  MAX_DIGIT = 4'd9;

endpackage

// File: rtl/dec2bin_acc_mul10_add.sv
// mul10_add
// Purely combinational acc*10 + d, built from two shifts and an add.
// The result is W+4 bits wide so that the largest case
// ((2^W-1)*10 + 15 < 16*2^W) never loses bits; the caller inspects the
// top four bits to detect overflow.
// Ports:
//   acc - current W-bit accumulator
//   d   - BCD digit
//   sum - (acc<<3) + (acc<<1) + d, W+4 bits
module mul10_add
   import dec2bin_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]       acc,
   input  logic [DIGIT_W-1:0] d,
   output logic [W+3:0]       sum
);

   logic [W+3:0] acc_x;

   assign acc_x = {4'b0000, acc};
   assign sum   = (acc_x << 3) + (acc_x << 1) + {{W{1'b0}}, d};

endmodule

// File: rtl/dec2bin_acc.sv
// dec2bin_acc
// Converts a stream of BCD digits (most significant first) into a W-bit
// binary value. Digits are accepted in ACCUM; the digit flagged last moves
// the block to OUT, where bin/err/ovf are held with bin_valid until the
// consumer takes them.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   digit, digit_valid,
//   digit_last, digit_ready  - digit input handshake
//   bin, err, ovf,
//   bin_valid, bin_ready     - result output handshake
// Build option: DEC2BIN_SAT_EN - saturate the accumulator at 2^W-1 on
// overflow instead of wrapping modulo 2^W.
module dec2bin_acc
   import dec2bin_pkg::*;
#(
   parameter int W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               digit_valid,
   input  logic               digit_last,
   output logic               digit_ready,
   output logic [W-1:0]       bin,
   output logic               bin_valid,
   input  logic               bin_ready,
   output logic               err,
   output logic               ovf
);

   state_e         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic           err_q, err_d;
   logic           ovf_q, ovf_d;
   logic [W+3:0]   sum;

   mul10_add #(.W(W)) u_mul10_add (
      .acc (acc_q),
      .d   (digit),
      .sum (sum)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      case (state_q)
         ACCUM: begin
            if (digit_valid) begin
               if (digit > MAX_DIGIT) begin
                  // Bad digit: remember it, but leave the value alone.
                  err_d = 1'b1;
               end else if (sum[W+3:W] != 4'd0) begin
                  ovf_d = 1'b1;
`ifdef DEC2BIN_SAT_EN
                  // Once pinned at max, every later digit overflows again,
                  // so the value stays pinned for the rest of the number.
                  acc_d = {W{1'b1}};
`else
                  acc_d = sum[W-1:0];
`endif
               end else begin
                  acc_d = sum[W-1:0];
               end
               if (digit_last) state_d = OUT;
            end
         end
         OUT: begin
            if (bin_ready) begin
               state_d = ACCUM;
               acc_d   = '0;
               err_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign digit_ready = (state_q == ACCUM);
   assign bin_valid   = (state_q == OUT);
   assign bin         = acc_q;
   assign err         = err_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_dec2bin_acc.sv
// tb_dec2bin_acc
// Self-checking bench for dec2bin_acc (W=16). Inputs are driven and outputs
// sampled on the falling clock edge. Expected values come from a decimal
// reference computed with plain integer arithmetic over the digit list.
// Honors DEC2BIN_SAT_EN the same way as the design.
module tb_dec2bin_acc;
   localparam int W = 16;
   localparam longint unsigned LIMIT = 64'd1 << W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   digit = 4'd0;
   logic         digit_valid = 1'b0;
   logic         digit_last = 1'b0;
   logic         bin_ready = 1'b0;
   logic         digit_ready;
   logic [W-1:0] bin;
   logic         bin_valid, err, ovf;

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned     num_q[$];
   logic [W-1:0]    got_bin;
   logic            got_err, got_ovf;

   always #5 clk = ~clk;

   dec2bin_acc #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit       (digit),
      .digit_valid (digit_valid),
      .digit_last  (digit_last),
      .digit_ready (digit_ready),
      .bin         (bin),
      .bin_valid   (bin_valid),
      .bin_ready   (bin_ready),
      .err         (err),
      .ovf         (ovf)
   );

   // Decimal value of the first n digits of num_q: illegal digits are skipped
   // and flag e; any value beyond 2^W-1 flags o and is saturated or wrapped.
   task automatic model(input int n, output longint unsigned v,
                        output bit e, output bit o);
      v = 0; e = 0; o = 0;
      for (int i = 0; i < n; i++) begin
         if (num_q[i] > 9) e = 1;
         else begin
            v = v * 10 + num_q[i];
            if (v >= LIMIT) begin
               o = 1;
`ifdef DEC2BIN_SAT_EN
               v = LIMIT - 1;
`else
               v = v % LIMIT;
`endif
            end
         end
      end
   endtask

   // Feeds num_q as one number, holds bin_ready low for `hold` cycles
   // (optionally offering stray digits), then completes the handshake.
   task automatic send_number(input string tag, input int hold, input bit offer);
      longint unsigned ev; bit ee, eo;
      for (int i = 0; i < num_q.size(); i++) begin
         @(negedge clk);
         model(i, ev, ee, eo);
         n_tests++;
         if (digit_ready !== 1'b1 || bin_valid !== 1'b0 || bin !== W'(ev)) begin
            n_fail++;
            $display("FAIL %s accum[%0d]: rdy=%0b vld=%0b bin=%0d, need rdy=1 vld=0 bin=%0d",
                     tag, i, digit_ready, bin_valid, bin, ev);
         end
         digit       = 4'(num_q[i]);
         digit_valid = 1'b1;
         digit_last  = (i == num_q.size() - 1);
      end
      @(negedge clk);
      digit_valid = 1'b0;
      digit_last  = 1'b0;
      model(num_q.size(), ev, ee, eo);
      got_bin = bin; got_err = err; got_ovf = ovf;
      n_tests++;
      if (bin_valid !== 1'b1 || bin !== W'(ev) || err !== ee || ovf !== eo) begin
         n_fail++;
         $display("FAIL %s result: vld=%0b bin=%0d err=%0b ovf=%0b, need vld=1 bin=%0d err=%0b ovf=%0b",
                  tag, bin_valid, bin, err, ovf, ev, ee, eo);
      end
      for (int k = 0; k < hold; k++) begin
         if (offer) begin
            digit       = 4'($urandom_range(0, 9));
            digit_valid = 1'b1;
            digit_last  = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         n_tests++;
         if (bin_valid !== 1'b1 || bin !== W'(ev) || err !== ee || ovf !== eo
             || digit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold[%0d]: vld=%0b rdy=%0b bin=%0d err=%0b ovf=%0b, need vld=1 rdy=0 bin=%0d err=%0b ovf=%0b",
                     tag, k, bin_valid, digit_ready, bin, err, ovf, ev, ee, eo);
         end
      end
      digit_valid = 1'b0;
      digit_last  = 1'b0;
      bin_ready   = 1'b1;
      @(negedge clk);
      bin_ready = 1'b0;
      n_tests++;
      if (bin_valid !== 1'b0 || digit_ready !== 1'b1 || bin !== '0 || err !== 1'b0
          || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_hs: vld=%0b rdy=%0b bin=%0d err=%0b ovf=%0b, need 0 1 0 0 0",
                  tag, bin_valid, digit_ready, bin, err, ovf);
      end
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (bin !== '0 || bin_valid !== 1'b0 || err !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: bin=%0d vld=%0b err=%0b ovf=%0b, need all 0", bin, bin_valid, err, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (digit_ready !== 1'b1 || bin_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: rdy=%0b vld=%0b, need rdy=1 vld=0", digit_ready, bin_valid);
      end
   endtask

   task automatic test_basic();
      num_q = '{1, 2, 3};
      send_number("basic_123", 0, 0);
      n_tests++;
      if (got_bin !== 16'd123 || got_err !== 1'b0 || got_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_123 const: bin=%0d err=%0b ovf=%0b, need 123 0 0", got_bin, got_err, got_ovf);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] need;
`ifdef DEC2BIN_SAT_EN
      need = 16'd65535;
`else
      need = 16'd0;
`endif
      num_q = '{6, 5, 5, 3, 6};
      send_number("ovf_65536", 1, 0);
      n_tests++;
      if (got_bin !== need || got_ovf !== 1'b1 || got_err !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_65536 const: bin=%0d ovf=%0b err=%0b, need %0d 1 0", got_bin, got_ovf, got_err, need);
      end
   endtask

   task automatic test_err_digit();
      num_q = '{4, 12, 2};
      send_number("err_4C2", 0, 0);
      n_tests++;
      if (got_bin !== 16'd42 || got_err !== 1'b1 || got_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL err_4C2 const: bin=%0d err=%0b ovf=%0b, need 42 1 0", got_bin, got_err, got_ovf);
      end
   endtask

   task automatic test_hold();
      num_q = '{7};
      send_number("hold_7", 5, 1);
      n_tests++;
      if (got_bin !== 16'd7) begin
         n_fail++;
         $display("FAIL hold_7 const: bin=%0d, need 7", got_bin);
      end
      // Stray digits offered in OUT must not leak into the next number.
      num_q = '{1};
      send_number("after_hold", 0, 0);
   endtask

   task automatic test_reset_mid();
      num_q = '{9, 9};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         digit = 4'd9; digit_valid = 1'b1; digit_last = 1'b0;
      end
      @(negedge clk);
      digit_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bin !== '0 || bin_valid !== 1'b0 || err !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: bin=%0d vld=%0b err=%0b ovf=%0b, need all 0", bin, bin_valid, err, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      num_q = '{5};
      send_number("reset_then_5", 0, 0);
      n_tests++;
      if (got_bin !== 16'd5 || got_err !== 1'b0 || got_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_then_5 const: bin=%0d err=%0b ovf=%0b, need 5 0 0", got_bin, got_err, got_ovf);
      end
   endtask

   task automatic test_random();
      int len;
      for (int n = 0; n < 40; n++) begin
         num_q.delete();
         len = $urandom_range(1, 7);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 7) == 0) num_q.push_back($urandom_range(10, 15));
            else                            num_q.push_back($urandom_range(0, 9));
         end
         send_number($sformatf("rand%0d", n), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_err_digit();
      test_hold();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule
